// File: rtl/io_pkg.sv
// Shared constants and types for the CPU I/O path (IN/OUT units).
// Holds opcodes, IN address map, the input FSM state enum and a sign-extend helper.
package io_pkg;

  localparam logic [5:0] OP_IN  = 6'b011011;
  localparam logic [5:0] OP_OUT = 6'b011100;

  localparam logic [4:0] ADDR_SW_LAST = 5'h11;
  localparam logic [4:0] ADDR_KEY1    = 5'h13;
  localparam logic [4:0] ADDR_KEY2    = 5'h14;
  localparam logic [4:0] ADDR_KEY3    = 5'h15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE
  } in_state_t;

  function automatic logic [31:0] sext_sw(input logic [17:0] s);
    return {{14{s[17]}}, s};
  endfunction

endpackage

// File: rtl/switch_input_unit_if.sv
// CPU-side bus of the IN unit: request/address in, data/valid/busy out.
// master = control unit side, slave = switch_input_unit side.
interface switch_input_unit_if;
  logic        req;
  logic [4:0]  address;
  logic [31:0] data_out;
  logic        valid;
  logic        busy;

  modport master (
    output req, address,
    input  data_out, valid, busy
  );

  modport slave (
    input  req, address,
    output data_out, valid, busy
  );
endinterface

// File: rtl/switch_input_unit_key_debouncer.sv
// key_debouncer: 2-flop synchroniser plus stable-count debouncer for one key.
// Ports: clk, reset (sync, active-low), raw (async, idle high), level (debounced).
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // input has differed for DEBOUNCE_CYCLES cycles in a row
        cnt   <= '0;
        level <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_input_unit.sv
// IN-instruction unit: reads synchronised switches (blocking on key1) or keys.
// Ports: clk, reset (sync, active-low), sw[17:0], key_n[3:1], bus (slave).
module switch_input_unit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] sw,
  input  logic [3:1]  key_n,
  switch_input_unit_if.slave bus
);
  import io_pkg::*;

  logic [17:0] sw_s1;
  logic [17:0] sw_s2;
  logic [3:1]  key_lvl;
  logic [3:1]  pressed;
  logic        pressed1_d;
  logic        rise1;
  logic [31:0] imm_word;
  in_state_t   state;

  for (genvar k = 1; k <= 3; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (key_n[k]),
      .level(key_lvl[k])
    );
  end

  assign pressed  = ~key_lvl;
  assign rise1    = pressed[1] & ~pressed1_d;
  assign bus.busy = (state != IDLE);

  always_comb begin
    imm_word = '0;
    unique case (1'b1)
      bus.address == ADDR_KEY1: imm_word = {31'b0, pressed[1]};
      bus.address == ADDR_KEY2: imm_word = {31'b0, pressed[2]};
      bus.address == ADDR_KEY3: imm_word = {31'b0, pressed[3]};
      default:                  imm_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      bus.data_out <= '0;
      bus.valid    <= 1'b0;
      pressed1_d   <= 1'b0;
      sw_s1        <= '0;
      sw_s2        <= '0;
    end else begin
      sw_s1      <= sw;
      sw_s2      <= sw_s1;
      pressed1_d <= pressed[1];
      bus.valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            if (bus.address <= ADDR_SW_LAST) begin
              state <= WAIT_PRESS;
            end else begin
              bus.data_out <= imm_word;
              bus.valid    <= 1'b1;
            end
          end
        end
        WAIT_PRESS: begin
          // a key already held at request time never rises here
          if (rise1) begin
            bus.data_out <= sext_sw(sw_s2);
            bus.valid    <= 1'b1;
            state        <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!pressed[1]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_input_unit.sv
// Testbench for switch_input_unit: directed tables, corner sequences, random vs model.
// Uses DEBOUNCE_CYCLES=4.
module tb_switch_input_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] sw = '0;
  logic [3:1]  key_n = 3'b111;

  int total = 0;
  int bad = 0;
  int nvalid = 0;
  bit mchk = 1'b0;

  always #5 clk = ~clk;

  switch_input_unit_if bus ();

  switch_input_unit #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw),
    .key_n(key_n),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) nvalid += int'(bus.valid);

  // ---------------- reference model ----------------
  // Keys: sampled value reaches the debouncer two edges later; a key's
  // pressed state flips once the last D delayed samples all disagree with it.
  typedef enum {M_IDLE, M_WP, M_WR} mst_t;
  mst_t        ms = M_IDLE;
  bit   [3:1]  mp;
  bit          mpd1;
  bit   [3:1]  kq[$];
  bit   [17:0] swq[$];
  bit   [3:1]  kh[$];
  logic [31:0] m_data;
  bit          m_valid;

  function automatic logic [31:0] m_imm(input logic [4:0] a, input bit [3:1] p);
    if (a == 5'h13) return {31'b0, p[1]};
    if (a == 5'h14) return {31'b0, p[2]};
    if (a == 5'h15) return {31'b0, p[3]};
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    bit [3:1]  s2;
    bit [17:0] sws;
    bit [3:1]  old_p;
    bit        all_diff;
    if (!reset) begin
      ms = M_IDLE; m_data = 32'h0; m_valid = 1'b0;
      mp = '0; mpd1 = 1'b0;
      kq = {3'b111, 3'b111};
      swq = {18'h0, 18'h0};
      kh = {};
      for (int j = 0; j < D; j++) kh.push_back(3'b111);
    end else begin
      s2 = kq[0];
      sws = swq[0];
      old_p = mp;
      m_valid = 1'b0;
      case (ms)
        M_IDLE: if (bus.req) begin
          if (bus.address <= 5'd17) ms = M_WP;
          else begin
            m_data = m_imm(bus.address, old_p);
            m_valid = 1'b1;
          end
        end
        M_WP: if (old_p[1] && !mpd1) begin
          m_data = {{14{sws[17]}}, sws};
          m_valid = 1'b1;
          ms = M_WR;
        end
        M_WR: if (!old_p[1]) ms = M_IDLE;
        default: ms = M_IDLE;
      endcase
      mpd1 = old_p[1];
      kh.push_back(s2);
      void'(kh.pop_front());
      for (int k = 1; k <= 3; k++) begin
        all_diff = 1'b1;
        // raw is active-low: a sample equal to pressed means it disagrees
        foreach (kh[j]) if (kh[j][k] != old_p[k]) all_diff = 1'b0;
        if (all_diff) mp[k] = ~old_p[k];
      end
      void'(kq.pop_front());
      kq.push_back(key_n);
      void'(swq.pop_front());
      swq.push_back(sw);
    end
  end

  always @(negedge clk) begin
    if (mchk) begin
      chk("model_valid", {31'b0, bus.valid}, {31'b0, m_valid});
      chk("model_data", bus.data_out, m_data);
      chk("model_busy", {31'b0, bus.busy}, {31'b0, ms != M_IDLE});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic issue(input logic [4:0] a);
    bus.req = 1'b1;
    bus.address = a;
    tick(1);
    bus.req = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (bus.valid) begin
        lat = i;
        break;
      end
    end
    chk(name, {31'b0, bus.valid}, 32'h1);
  endtask

  task automatic blocking_read(input string name, input logic [17:0] s,
                               input logic [31:0] exp);
    int lat;
    sw = s;
    tick(3);
    issue(5'h00);
    chk({name, "_busy"}, {31'b0, bus.busy}, 32'h1);
    chk({name, "_novalid"}, {31'b0, bus.valid}, 32'h0);
    nvalid = 0;
    key_n[1] = 1'b0;
    wait_valid({name, "_valid"}, lat);
    chk({name, "_lat"}, lat, D + 3);
    chk({name, "_data"}, bus.data_out, exp);
    chk({name, "_busy_hold"}, {31'b0, bus.busy}, 32'h1);
    tick(1);
    chk({name, "_pulse"}, {31'b0, bus.valid}, 32'h0);
    key_n[1] = 1'b1;
    tick(D + 4);
    chk({name, "_idle"}, {31'b0, bus.busy}, 32'h0);
    chk({name, "_count"}, nvalid, 1);
  endtask

  typedef struct {
    logic [3:1]  keys;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    bus.req = 1'b0;
    bus.address = '0;

    vecs[0] = '{3'b101, 5'h14, 32'h1};
    vecs[1] = '{3'b101, 5'h1A, 32'h0};
    vecs[2] = '{3'b101, 5'h13, 32'h0};
    vecs[3] = '{3'b101, 5'h15, 32'h0};
    vecs[4] = '{3'b011, 5'h15, 32'h1};
    vecs[5] = '{3'b011, 5'h12, 32'h0};
    vecs[6] = '{3'b110, 5'h13, 32'h1};
    vecs[7] = '{3'b110, 5'h1F, 32'h0};

    // reset
    tick(3);
    chk("rst_data", bus.data_out, 32'h0);
    chk("rst_valid", {31'b0, bus.valid}, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    mchk = 1'b1;
    reset = 1'b1;
    tick(2);
    chk("rel_data", bus.data_out, 32'h0);
    chk("rel_valid", {31'b0, bus.valid}, 32'h0);
    chk("rel_busy", {31'b0, bus.busy}, 32'h0);

    // immediate reads
    foreach (vecs[i]) begin
      key_n = vecs[i].keys;
      tick(D + 4);
      issue(vecs[i].addr);
      chk("imm_valid", {31'b0, bus.valid}, 32'h1);
      chk("imm_data", bus.data_out, vecs[i].data);
      chk("imm_busy", {31'b0, bus.busy}, 32'h0);
      tick(1);
      chk("imm_pulse", {31'b0, bus.valid}, 32'h0);
      chk("imm_hold", bus.data_out, vecs[i].data);
    end
    key_n = 3'b111;
    tick(D + 4);

    blocking_read("neg", 18'h3FFFB, 32'hFFFFFFFB);
    blocking_read("pos", 18'h0007B, 32'h0000007B);

    // bounce during WAIT_PRESS
    sw = 18'h00155;
    tick(3);
    issue(5'h05);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      key_n[1] = ~key_n[1];
      tick(2);
    end
    chk("bounce_none", nvalid, 0);
    chk("bounce_busy", {31'b0, bus.busy}, 32'h1);
    key_n[1] = 1'b0;
    wait_valid("bounce_valid", lat);
    chk("bounce_data", bus.data_out, 32'h00000155);
    tick(6);
    chk("bounce_once", nvalid, 1);
    key_n[1] = 1'b1;
    tick(D + 4);
    chk("bounce_idle", {31'b0, bus.busy}, 32'h0);

    // key1 already held at request
    key_n[1] = 1'b0;
    tick(D + 4);
    nvalid = 0;
    issue(5'h02);
    chk("held_busy", {31'b0, bus.busy}, 32'h1);
    tick(10);
    chk("held_none", nvalid, 0);
    key_n[1] = 1'b1;
    tick(D + 4);
    chk("held_rel_none", nvalid, 0);
    chk("held_rel_busy", {31'b0, bus.busy}, 32'h1);
    key_n[1] = 1'b0;
    wait_valid("held_valid", lat);
    chk("held_data", bus.data_out, 32'h00000155);
    key_n[1] = 1'b1;
    tick(D + 4);
    chk("held_once", nvalid, 1);
    chk("held_idle", {31'b0, bus.busy}, 32'h0);

    // reset mid-wait
    issue(5'h03);
    chk("rmw_busy", {31'b0, bus.busy}, 32'h1);
    nvalid = 0;
    reset = 1'b0;
    tick(1);
    chk("rmw_busy0", {31'b0, bus.busy}, 32'h0);
    chk("rmw_data0", bus.data_out, 32'h0);
    reset = 1'b1;
    key_n[1] = 1'b0;
    tick(D + 5);
    chk("rmw_none", nvalid, 0);
    chk("rmw_idle", {31'b0, bus.busy}, 32'h0);
    key_n[1] = 1'b1;
    tick(D + 4);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.req = ($urandom_range(7) == 0);
      bus.address = 5'($urandom);
      sw = 18'($urandom);
      if ($urandom_range(5) == 0) key_n[$urandom_range(3, 1)] ^= 1'b1;
      reset = ($urandom_range(599) != 0);
      tick(1);
    end
    bus.req = 1'b0;
    reset = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_input_unit.md
# switch_input_unit

Input-side counterpart of the processor's display output path: services the CPU's IN instruction (opcode 6'b011011) by reading the board switches and push-buttons. Keys are debounced and switches synchronised. Switch reads are blocking: the CPU stalls until the user confirms with key1. The unit returns a 32-bit word with a one-cycle valid strobe that the CPU writes to its destination register.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a debounced key changes (1 ms at 50 MHz).
- CNT_W, default 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-low.
- req  in  1  one-cycle IN request from the control unit; only sampled in IDLE.
- address  in  5  IN target address.
- sw  in  18  raw slide switches, asynchronous.
- key_n  in  3  raw push-buttons key3..key1, asynchronous, active-low (pressed = 0).
- data_out  out  32  returned word; holds its value between transactions.
- valid  out  1  one-cycle strobe; data_out is valid in the same cycle.
- busy  out  1  high while waiting for user confirmation; the CPU stalls on busy.

## Operation
- Switch path: 2-flop synchroniser per bit; no debounce.
- Key path: 2-flop synchroniser, then a debouncer per key. Internal pressed[k] = debounced inverse of key_n[k].
- Rise detect on pressed[1] only: rise1 = pressed[1] & ~pressed1_d.
- Address classes (decided in IDLE on req):
  - 0x00–0x11 (switch read): blocking. Word = {{14{sw17}}, sw[17:0]}, an 18-bit signed value sign-extended to 32 bits.
  - 0x13, 0x14, 0x15: immediate read of pressed[1], pressed[2] or pressed[3]. Word = {31'b0, pressed[k]}.
  - 0x12 and 0x16–0x1F: immediate. Word = 32'h0.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE.
  - IDLE with req and a switch address goes to WAIT_PRESS.
  - IDLE with req and any other address: data_out and valid are registered; FSM stays in IDLE.
  - WAIT_PRESS with rise1: capture the synchronised switches into data_out, pulse valid, go to WAIT_RELEASE.
  - WAIT_RELEASE with pressed[1]==0: go to IDLE.
- busy = (state != IDLE).
- req outside IDLE is ignored and not queued.
- Reset values: data_out=0, valid=0, busy=0, state=IDLE, all debounced pressed=0, counters=0, synchroniser flops=1 for keys and 0 for switches.

## Timing
- Immediate read: req in cycle N gives valid=1 and data_out in cycle N+1. busy stays 0.
- Blocking read:
  - req in cycle N raises busy in N+1.
  - rise1 in cycle M gives valid and data_out in M+1, with busy still 1.
  - busy falls in the cycle after pressed[1] is observed 0 in WAIT_RELEASE.
- Debounce:
  - When the synchronised key differs from its debounced value, the counter increments each cycle; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value toggles next cycle and the counter clears.
  - Any bounce restarts the count.
- Raw-to-pressed latency: 2 synchroniser cycles + DEBOUNCE_CYCLES.
- Key1 already held when the request arrives: no rise occurs, so the unit waits for a release followed by a fresh press.
- Reset asserted mid-transaction: FSM returns to IDLE on the next edge, no valid is produced, and data_out clears to 0.
- valid is never high for more than one cycle per transaction.

## Structure
- Shared package io_pkg holds:
  - the opcode constants OP_IN=6'b011011 and OP_OUT=6'b011100;
  - the address constants ADDR_SW_LAST=5'h11, ADDR_KEY1=5'h13, ADDR_KEY2=5'h14, ADDR_KEY3=5'h15;
  - the FSM state enum.
- Sub-module key_debouncer (parameters DEBOUNCE_CYCLES and CNT_W; ports clk, reset, raw, level): contains the synchroniser and the debounce counter. It is instantiated three times.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Reset: hold reset=0 for 3 cycles -> data_out=0, valid=0, busy=0. Release with all keys up -> outputs unchanged.
- Immediate key read: hold key_n[2]=0 until debounced, then req with address 0x14 -> valid in the next cycle, data_out=32'h1, busy stays 0. Address 0x1A -> data_out=32'h0.
- Blocking switch read, negative value:
  - sw=18'h3FFFB, req with address 0x00 -> busy=1.
  - Press key1 -> valid with data_out=32'hFFFFFFFB.
  - Release key1 -> busy=0.
- Blocking read, positive value: sw=18'h0007B -> data_out=32'h0000007B.
- Bounce: toggle key_n[1] every 2 cycles during WAIT_PRESS -> no valid. Then hold low 4+ cycles -> exactly one valid.
- Key held at request, and reset mid-wait:
  - key1 held down when req arrives -> no valid until a release and re-press.
  - reset pulse during WAIT_PRESS -> IDLE, busy=0, no valid, data_out=0.
